// File: rtl/rsc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rsc_pkg
//  Purpose  : Shared defaults, FSM state type and helpers for the RSC
//             terminated constituent encoder.
//  Revision : 1.0 - initial release
// ============================================================================
package rsc_pkg;

    // Default encoder memory and generator polynomials (MSB = D^0).
    localparam int         c_DEF_K_MEM = 3;
    localparam logic [3:0] c_DEF_G_FB  = 4'b1011;  // g0, octal 13
    localparam logic [3:0] c_DEF_G_FF  = 4'b1101;  // g1, octal 15

    // Encoder control states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_TAIL = 2'd2
    } rsc_state_t;

    // Width of a counter that must hold 0..k.
    function automatic int tail_cnt_width(input int k);
        return (k < 1) ? 1 : $clog2(k + 1);
    endfunction

    localparam int c_DEF_TCNT_W = tail_cnt_width(c_DEF_K_MEM);

endpackage : rsc_pkg
`default_nettype wire

// File: rtl/rsc_core.sv
`default_nettype none
// ============================================================================
//  Module   : rsc_core
//  Purpose  : Combinational RSC datapath: feedback, parity and next shift
//             register contents. In tail mode the input bit is replaced by
//             the feedback sum so the new feedback bit is zero, which walks
//             the register back to the all-zero state in K_MEM steps.
//  Revision : 1.0 - initial release
// ============================================================================
module rsc_core
    import rsc_pkg::*;
#(
    parameter int             K_MEM = c_DEF_K_MEM,
    parameter logic [K_MEM:0] G_FB  = c_DEF_G_FB,
    parameter logic [K_MEM:0] G_FF  = c_DEF_G_FF
) (
    input  logic             i_x,
    input  logic [K_MEM-1:0] i_s,          // i_s[i-1] holds s_i
    input  logic             i_force_tail,
    output logic             o_sys,
    output logic             o_par,
    output logic [K_MEM-1:0] o_s_next
);

    logic w_fb;   // feedback contribution of the register (excluding x)
    logic w_ff;   // feedforward contribution of the register (excluding a)
    logic w_x;
    logic w_a;

    // XOR-reduce the register taps selected by each polynomial.
    always_comb begin
        w_fb = 1'b0;
        w_ff = 1'b0;
        for (int i = 1; i <= K_MEM; i++) begin
            w_fb = w_fb ^ (G_FB[K_MEM-i] & i_s[i-1]);
            w_ff = w_ff ^ (G_FF[K_MEM-i] & i_s[i-1]);
        end
    end

    assign w_x      = i_force_tail ? w_fb : i_x;
    assign w_a      = w_x ^ w_fb;
    assign o_sys    = w_x;
    assign o_par    = (G_FF[K_MEM] & w_a) ^ w_ff;
    assign o_s_next = {i_s[K_MEM-2:0], w_a};

endmodule : rsc_core
`default_nettype wire

// File: rtl/rsc_term_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : rsc_term_encoder
//  Purpose  : RSC constituent encoder with trellis termination. Encodes data
//             bits while en is high; after the bit flagged by switch it emits
//             K_MEM tail pairs that return the register to zero and pulses
//             done on the last one. All outputs are registered.
//  Revision : 1.0 - initial release
// ============================================================================
module rsc_term_encoder
    import rsc_pkg::*;
#(
    parameter int             K_MEM = c_DEF_K_MEM,
    parameter logic [K_MEM:0] G_FB  = c_DEF_G_FB,
    parameter logic [K_MEM:0] G_FF  = c_DEF_G_FF
) (
    input  logic clk,
    input  logic clr,
    input  logic en,
    input  logic switch,
    input  logic data_in,
    output logic sys_out,
    output logic par_out,
    output logic out_valid,
    output logic tail_out,
    output logic done,
    output logic overrun
);

    localparam int               c_TCW       = tail_cnt_width(K_MEM);
    localparam logic [c_TCW-1:0] c_TCNT_LAST = c_TCW'(K_MEM - 1);

    rsc_state_t       r_state;
    logic [K_MEM-1:0] r_s;
    logic [c_TCW-1:0] r_tcnt;
    logic             r_sys;
    logic             r_par;
    logic             r_valid;
    logic             r_tail;
    logic             r_done;
    logic             r_overrun;

    logic             w_force_tail;
    logic             w_sys;
    logic             w_par;
    logic [K_MEM-1:0] w_s_next;

    assign w_force_tail = (r_state == ST_TAIL);

    rsc_core #(
        .K_MEM (K_MEM),
        .G_FB  (G_FB),
        .G_FF  (G_FF)
    ) u_core (
        .i_x          (data_in),
        .i_s          (r_s),
        .i_force_tail (w_force_tail),
        .o_sys        (w_sys),
        .o_par        (w_par),
        .o_s_next     (w_s_next)
    );

    // Control FSM, shift register, tail counter and output registers.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state   <= ST_IDLE;
            r_s       <= '0;
            r_tcnt    <= '0;
            r_sys     <= 1'b0;
            r_par     <= 1'b0;
            r_valid   <= 1'b0;
            r_tail    <= 1'b0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            // Pulses and pair outputs drop unless a pair is produced.
            r_sys     <= 1'b0;
            r_par     <= 1'b0;
            r_valid   <= 1'b0;
            r_tail    <= 1'b0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DATA: begin
                    // Gaps (en=0) hold register and state; switch is ignored.
                    if (en) begin
                        r_s     <= w_s_next;
                        r_sys   <= w_sys;
                        r_par   <= w_par;
                        r_valid <= 1'b1;
                        r_tcnt  <= '0;
                        r_state <= switch ? ST_TAIL : ST_DATA;
                    end
                end
                ST_TAIL: begin
                    // Tail runs regardless of en; any incoming bit is dropped.
                    r_s       <= w_s_next;
                    r_sys     <= w_sys;
                    r_par     <= w_par;
                    r_valid   <= 1'b1;
                    r_tail    <= 1'b1;
                    r_overrun <= en;
                    if (r_tcnt == c_TCNT_LAST) begin
                        r_done  <= 1'b1;
                        r_tcnt  <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_tcnt  <= r_tcnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_s     <= '0;
                    r_tcnt  <= '0;
                end
            endcase
        end
    end

    assign sys_out   = r_sys;
    assign par_out   = r_par;
    assign out_valid = r_valid;
    assign tail_out  = r_tail;
    assign done      = r_done;
    assign overrun   = r_overrun;

endmodule : rsc_term_encoder
`default_nettype wire

// File: tb/tb_rsc_term_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rsc_term_encoder
//  Purpose  : Self-checking bench for rsc_term_encoder. A reference model in
//             polynomial-division form (history of feedback bits) predicts
//             every output pair; directed scenarios plus random blocks.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rsc_term_encoder;

    localparam int         K_MEM = 3;
    localparam logic [3:0] G_FB  = 4'b1011;
    localparam logic [3:0] G_FF  = 4'b1101;

    typedef struct packed {
        logic sys;
        logic par;
        logic tail;
        logic done;
    } pair_t;

    typedef struct packed {
        logic clr;
        logic en;
        logic sw;
        logic d;
    } stim_t;

    logic clk, clr, en, switch, data_in;
    logic sys_out, par_out, out_valid, tail_out, done, overrun;

    int n_checks = 0;
    int n_errors = 0;

    pair_t cap_q[$];
    pair_t exp_q[$];
    stim_t stim[$];
    logic  vtrace[$];
    int    ovr_cnt;
    int    done_cnt;
    int    nz_cnt;

    rsc_term_encoder #(
        .K_MEM (K_MEM),
        .G_FB  (G_FB),
        .G_FF  (G_FF)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .en        (en),
        .switch    (switch),
        .data_in   (data_in),
        .sys_out   (sys_out),
        .par_out   (par_out),
        .out_valid (out_valid),
        .tail_out  (tail_out),
        .done      (done),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Capture outputs mid-cycle, away from the active edge.
    always @(negedge clk) begin
        vtrace.push_back(out_valid);
        if (out_valid) cap_q.push_back({sys_out, par_out, tail_out, done});
        if (overrun) ovr_cnt++;
        if (done) begin
            done_cnt++;
            if (dut.r_s != '0) nz_cnt++;
        end
    end

    // Reference: a_t = x_t ^ sum g0_i a_(t-i), z_t = sum g1_i a_(t-i) (i=0..K).
    // Tail input is chosen so that a_t = 0.
    task automatic model_block(input logic [31:0] bits, input int len);
        logic  a_hist[$];
        pair_t p;
        for (int t = 0; t < len + K_MEM; t++) begin
            logic fb, ff, x, a;
            fb = 1'b0;
            ff = 1'b0;
            for (int i = 1; i <= K_MEM; i++) begin
                if (t - i >= 0) begin
                    fb = fb ^ (G_FB[K_MEM-i] & a_hist[t-i]);
                    ff = ff ^ (G_FF[K_MEM-i] & a_hist[t-i]);
                end
            end
            x = (t < len) ? bits[len-1-t] : fb;
            a = x ^ fb;
            a_hist.push_back(a);
            p.sys  = x;
            p.par  = (G_FF[K_MEM] & a) ^ ff;
            p.tail = (t >= len);
            p.done = (t == len + K_MEM - 1);
            exp_q.push_back(p);
        end
    endtask

    // Queue a contiguous block (first bit = bits[len-1]) and its prediction.
    task automatic add_block(input logic [31:0] bits, input int len);
        for (int j = 0; j < len; j++)
            stim.push_back({1'b0, 1'b1, (j == len - 1), bits[len-1-j]});
        model_block(bits, len);
    endtask

    task automatic add_idle(input int n);
        for (int j = 0; j < n; j++) stim.push_back(4'b0000);
    endtask

    task automatic play(input int drain);
        foreach (stim[i]) begin
            @(negedge clk);
            clr = stim[i].clr; en = stim[i].en; switch = stim[i].sw; data_in = stim[i].d;
        end
        @(negedge clk);
        clr = 1'b0; en = 1'b0; switch = 1'b0; data_in = 1'b0;
        repeat (drain) @(negedge clk);
    endtask

    task automatic new_test;
        @(posedge clk);
        #1;
        cap_q.delete(); exp_q.delete(); stim.delete(); vtrace.delete();
        ovr_cnt = 0; done_cnt = 0; nz_cnt = 0;
    endtask

    task automatic test_reset;
        clr = 1'b1; en = 1'b1; switch = 1'b1; data_in = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({sys_out, par_out, out_valid, tail_out, done, overrun} !== 6'b0) begin
            n_errors++;
            $display("FAIL reset_outputs got=%b want=000000",
                     {sys_out, par_out, out_valid, tail_out, done, overrun});
        end
        n_checks++;
        if (dut.r_s !== 3'b000) begin
            n_errors++;
            $display("FAIL reset_state got=%b want=000", dut.r_s);
        end
        clr = 1'b0; en = 1'b0; switch = 1'b0; data_in = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic;
        logic [6:0] sys_ref = 7'b1100010;
        logic [6:0] par_ref = 7'b1000110;
        new_test();
        add_block(32'b1100, 4);
        play(K_MEM + 4);
        n_checks++;
        if (cap_q.size() != 7) begin
            n_errors++;
            $display("FAIL basic_count got=%0d want=7", cap_q.size());
        end
        for (int i = 0; i < 7 && i < cap_q.size(); i++) begin
            n_checks++;
            if (cap_q[i] !== {sys_ref[6-i], par_ref[6-i], (i >= 4), (i == 6)}) begin
                n_errors++;
                $display("FAIL basic_pair%0d got=%b want=%b", i, cap_q[i],
                         {sys_ref[6-i], par_ref[6-i], (i >= 4), (i == 6)});
            end
        end
        n_checks++;
        if (dut.r_s !== 3'b000 || done_cnt != 1 || nz_cnt != 0) begin
            n_errors++;
            $display("FAIL basic_final s=%b done=%0d nz=%0d want s=000 done=1 nz=0",
                     dut.r_s, done_cnt, nz_cnt);
        end
    endtask

    task automatic test_single;
        logic [3:0] sys_ref = 4'b1011;
        logic [3:0] par_ref = 4'b1101;
        new_test();
        add_block(32'b1, 1);
        play(K_MEM + 4);
        n_checks++;
        if (cap_q.size() != 4) begin
            n_errors++;
            $display("FAIL single_count got=%0d want=4", cap_q.size());
        end
        for (int i = 0; i < 4 && i < cap_q.size(); i++) begin
            n_checks++;
            if (cap_q[i] !== {sys_ref[3-i], par_ref[3-i], (i >= 1), (i == 3)}) begin
                n_errors++;
                $display("FAIL single_pair%0d got=%b want=%b", i, cap_q[i],
                         {sys_ref[3-i], par_ref[3-i], (i >= 1), (i == 3)});
            end
        end
    endtask

    task automatic test_stall;
        int pos[$];
        new_test();
        model_block(32'b1100, 4);
        stim.push_back(4'b0101); stim.push_back(4'b0101);
        stim.push_back(4'b0010); stim.push_back(4'b0010);   // gap, switch must be ignored
        stim.push_back(4'b0100); stim.push_back(4'b0110);
        play(K_MEM + 4);
        foreach (vtrace[i]) if (vtrace[i]) pos.push_back(i);
        n_checks++;
        if (cap_q.size() != exp_q.size()) begin
            n_errors++;
            $display("FAIL stall_count got=%0d want=%0d", cap_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            n_checks++;
            if (cap_q[i] !== exp_q[i]) begin
                n_errors++;
                $display("FAIL stall_pair%0d got=%b want=%b", i, cap_q[i], exp_q[i]);
            end
        end
        n_checks++;
        if (pos.size() != 7 || pos[2] - pos[1] != 3 || pos[1] - pos[0] != 1 ||
            pos[6] - pos[2] != 4) begin
            n_errors++;
            $display("FAIL stall_gap got valid_pairs=%0d want 7 with 2-cycle gap after pair 2",
                     pos.size());
        end
    endtask

    task automatic test_overrun;
        new_test();
        add_block(32'b1100, 4);
        stim.push_back(4'b0000);
        stim.push_back(4'b0111);   // en during second tail cycle
        play(K_MEM + 4);
        n_checks++;
        if (ovr_cnt != 1) begin
            n_errors++;
            $display("FAIL overrun_pulses got=%0d want=1", ovr_cnt);
        end
        n_checks++;
        if (cap_q.size() != exp_q.size()) begin
            n_errors++;
            $display("FAIL overrun_count got=%0d want=%0d", cap_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            n_checks++;
            if (cap_q[i] !== exp_q[i]) begin
                n_errors++;
                $display("FAIL overrun_pair%0d got=%b want=%b", i, cap_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        int pos[$];
        new_test();
        add_block(32'b1100, 4);
        add_idle(K_MEM);
        add_block(32'b1100, 4);
        play(K_MEM + 4);
        foreach (vtrace[i]) if (vtrace[i]) pos.push_back(i);
        n_checks++;
        if (cap_q.size() != 14 || done_cnt != 2) begin
            n_errors++;
            $display("FAIL b2b_count got pairs=%0d done=%0d want pairs=14 done=2",
                     cap_q.size(), done_cnt);
        end
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            n_checks++;
            if (cap_q[i] !== exp_q[i]) begin
                n_errors++;
                $display("FAIL b2b_pair%0d got=%b want=%b", i, cap_q[i], exp_q[i]);
            end
        end
        n_checks++;
        if (pos.size() != 14 || pos[13] - pos[0] != 13) begin
            n_errors++;
            $display("FAIL b2b_bubble got valid_pairs=%0d want 14 contiguous", pos.size());
        end
    endtask

    task automatic test_clr_tail;
        new_test();
        add_block(32'b1100, 4);
        stim.push_back(4'b1111);   // clr in first tail cycle
        play(0);
        n_checks++;
        if ({sys_out, par_out, out_valid, tail_out, done, overrun} !== 6'b0 ||
            dut.r_s !== 3'b000) begin
            n_errors++;
            $display("FAIL clr_outputs got=%b s=%b want=000000 s=000",
                     {sys_out, par_out, out_valid, tail_out, done, overrun}, dut.r_s);
        end
        repeat (K_MEM + 4) @(negedge clk);
        n_checks++;
        if (done_cnt != 0 || cap_q.size() != 4) begin
            n_errors++;
            $display("FAIL clr_abandon got done=%0d pairs=%0d want done=0 pairs=4",
                     done_cnt, cap_q.size());
        end
        new_test();
        add_block(32'b1100, 4);
        play(K_MEM + 4);
        n_checks++;
        if (cap_q.size() != exp_q.size()) begin
            n_errors++;
            $display("FAIL clr_rerun_count got=%0d want=%0d", cap_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            n_checks++;
            if (cap_q[i] !== exp_q[i]) begin
                n_errors++;
                $display("FAIL clr_rerun_pair%0d got=%b want=%b", i, cap_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random;
        int exp_ovr = 0;
        int nblk = 8;
        new_test();
        for (int b = 0; b < nblk; b++) begin
            int          len;
            logic [31:0] bits;
            len  = $urandom_range(1, 12);
            bits = $urandom;
            for (int j = 0; j < len; j++) begin
                if ($urandom_range(0, 3) == 0)
                    stim.push_back({1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))});
                stim.push_back({1'b0, 1'b1, (j == len - 1), bits[len-1-j]});
            end
            model_block(bits, len);
            for (int j = 0; j < K_MEM; j++) begin
                logic e;
                e = 1'($urandom_range(0, 1));
                if (e) exp_ovr++;
                stim.push_back({1'b0, e, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))});
            end
            add_idle($urandom_range(0, 2));
        end
        play(K_MEM + 4);
        n_checks++;
        if (cap_q.size() != exp_q.size() || done_cnt != nblk) begin
            n_errors++;
            $display("FAIL rand_count got pairs=%0d done=%0d want pairs=%0d done=%0d",
                     cap_q.size(), done_cnt, exp_q.size(), nblk);
        end
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            n_checks++;
            if (cap_q[i] !== exp_q[i]) begin
                n_errors++;
                $display("FAIL rand_pair%0d got=%b want=%b", i, cap_q[i], exp_q[i]);
            end
        end
        n_checks++;
        if (ovr_cnt != exp_ovr || nz_cnt != 0) begin
            n_errors++;
            $display("FAIL rand_overrun got ovr=%0d nz=%0d want ovr=%0d nz=0",
                     ovr_cnt, nz_cnt, exp_ovr);
        end
    endtask

    initial begin
        clr = 1'b1; en = 1'b0; switch = 1'b0; data_in = 1'b0;
        ovr_cnt = 0; done_cnt = 0; nz_cnt = 0;
        test_reset();
        test_basic();
        test_single();
        test_stall();
        test_overrun();
        test_back_to_back();
        test_clr_tail();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_rsc_term_encoder
`default_nettype wire
